pwm_gate_guard: RTL and testbench

//  Downstream stage of the PWM carrier/compare block. It consumes U_Hi/U_Lo/Down and

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_gate_guard_gate_leg.sv | 65 ++++++
 rtl/pwm_gate_guard.sv | 160 ++++++++++++++++
 tb/tb_pwm_gate_guard.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared FSM encodings and timing defaults for the PWM gate path
// Purpose: state constants for the gate guard FSM, default timing values shared by
//          the gate path, and a saturating 16-bit increment helper.
// Ports:   none (package).
package pwm_pkg;

  // Guard FSM states (2-bit, kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_TRIP = 2'd3;

  // Shared timing defaults, in CLK cycles
  localparam logic [15:0] DEF_DEAD     = 16'h00f0;
  localparam logic [15:0] DEF_MIN_ON   = 16'h0010;
  localparam logic [15:0] DEF_LOCKOUT  = 16'h0008;
  localparam int          DEF_FLT_FILT = 4;

  // Counters in the gate path never wrap; they stick at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pwm_gate_guard_gate_leg.sv
// rtl/pwm_gate_guard_gate_leg.sv - one gate leg: on/off timers and turn-on/turn-off decision
// Purpose: owns one registered gate output. Measures how long the gate has been on and
//          off, enforces the minimum on-time and the lockout against the opposite leg.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   i_run_ok      guard is in RUN and will stay there this edge
//   i_req         registered request for this leg
//   i_req_opp     registered request for the opposite leg
//   i_g_opp       opposite leg gate
//   i_offcnt_opp  opposite leg off-time counter
//   o_g           this leg gate (registered)
//   o_offcnt      this leg off-time counter (to the opposite leg)
module gate_leg
  import pwm_pkg::*;
#(
  parameter logic [15:0] MIN_ON  = DEF_MIN_ON,
  parameter logic [15:0] LOCKOUT = DEF_LOCKOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_run_ok,
  input  logic        i_req,
  input  logic        i_req_opp,
  input  logic        i_g_opp,
  input  logic [15:0] i_offcnt_opp,
  output logic        o_g,
  output logic [15:0] o_offcnt
);

  logic        r_g;
  logic [15:0] r_oncnt;
  logic [15:0] r_offcnt;
  logic        w_min_met;
  logic        w_turn_on;
  logic        w_turn_off;

  always_comb begin
    // oncnt lags the gate by one edge, hence the -1; MIN_ON=0 means follow req
    w_min_met  = (MIN_ON == 16'd0) || (r_oncnt >= (MIN_ON - 16'd1));
    // requiring !i_req_opp keeps both legs off while both requests are high,
    // and makes simultaneous turn-on of both legs impossible
    w_turn_on  = i_run_ok & i_req & ~i_g_opp & ~i_req_opp & (i_offcnt_opp >= LOCKOUT);
    w_turn_off = (~i_req & w_min_met) | ~i_run_ok;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_g      <= 1'b0;
      r_oncnt  <= 16'h0000;
      r_offcnt <= 16'hffff;
    end else begin
      if (r_g) begin
        r_g <= ~w_turn_off;
      end else begin
        r_g <= w_turn_on;
      end
      r_oncnt  <= r_g ? sat_inc16(r_oncnt) : 16'h0000;
      r_offcnt <= r_g ? 16'h0000 : sat_inc16(r_offcnt);
    end
  end

  assign o_g      = r_g;
  assign o_offcnt = r_offcnt;

endmodule

// File: rtl/pwm_gate_guard.sv
// rtl/pwm_gate_guard.sv - final gate guard: interlock, min on-time, valley start, fault latch
// Purpose: last logic before the gate driver pins. Registers the PWM requests, filters
//          the external fault, runs the IDLE/ARM/RUN/TRIP FSM and drives two gate legs.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   Enable            1 = request run, 0 = stop
//   Fault_n           external fault, active-low, asynchronous to CLK
//   FltClr            fault clear request (level)
//   Down_in           carrier direction (0 = up, 1 = down)
//   U_Hi_in, U_Lo_in  high/low side requests
//   G_Hi, G_Lo        gate drives (registered)
//   Running, Fault    FSM in RUN / in TRIP
//   Ovl               both registered requests high
module pwm_gate_guard
  import pwm_pkg::*;
#(
  parameter logic [15:0] MIN_ON   = DEF_MIN_ON,
  parameter logic [15:0] LOCKOUT  = DEF_LOCKOUT,
  parameter int          FLT_FILT = DEF_FLT_FILT
) (
  input  logic CLK,
  input  logic RST,
  input  logic Enable,
  input  logic Fault_n,
  input  logic FltClr,
  input  logic Down_in,
  input  logic U_Hi_in,
  input  logic U_Lo_in,
  output logic G_Hi,
  output logic G_Lo,
  output logic Running,
  output logic Fault,
  output logic Ovl
);

  localparam logic [3:0] FLT_N = 4'(FLT_FILT);

  logic        r_u_hi;
  logic        r_u_lo;
  logic        r_down;
  logic        r_down_d;
  logic        r_flt_s1;
  logic        r_flt_s2;
  logic [3:0]  r_flt_cnt;
  logic [1:0]  r_state;
  logic        r_ovl;

  logic        w_flt_active;
  logic        w_valley;
  logic        w_run_ok;
  logic [1:0]  w_state_nxt;
  logic        w_g_hi;
  logic        w_g_lo;
  logic [15:0] w_off_hi;
  logic [15:0] w_off_lo;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_u_hi   <= 1'b0;
      r_u_lo   <= 1'b0;
      r_down   <= 1'b0;
      r_down_d <= 1'b0;
      r_ovl    <= 1'b0;
    end else begin
      r_u_hi   <= U_Hi_in;
      r_u_lo   <= U_Lo_in;
      r_down   <= Down_in;
      r_down_d <= r_down;
      r_ovl    <= r_u_hi & r_u_lo;
    end
  end

  // Fault_n synchroniser and consecutive-low filter; the count holds at FLT_N
  // for as long as the synced input stays low, which is the "active" condition.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_flt_s1  <= 1'b1;
      r_flt_s2  <= 1'b1;
      r_flt_cnt <= 4'd0;
    end else begin
      r_flt_s1 <= Fault_n;
      r_flt_s2 <= r_flt_s1;
      if (r_flt_s2) begin
        r_flt_cnt <= 4'd0;
      end else if (r_flt_cnt != FLT_N) begin
        r_flt_cnt <= r_flt_cnt + 4'd1;
      end
    end
  end

  assign w_flt_active = (r_flt_cnt == FLT_N);
  // Carrier valley: registered direction goes down -> up
  assign w_valley     = r_down_d & ~r_down;
  // Legs see "run" only when RUN survives this edge, so gates drop on the
  // same edge as a stop or a trip.
  assign w_run_ok     = (r_state == ST_RUN) & Enable & ~w_flt_active;

  always_comb begin
    w_state_nxt = r_state;
    if (w_flt_active) begin
      w_state_nxt = ST_TRIP;
    end else begin
      case (r_state)
        ST_IDLE: if (Enable) w_state_nxt = ST_ARM;
        ST_ARM: begin
          if (!Enable)       w_state_nxt = ST_IDLE;
          else if (w_valley) w_state_nxt = ST_RUN;
        end
        ST_RUN:  if (!Enable) w_state_nxt = ST_IDLE;
        ST_TRIP: if (FltClr && !Enable) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  gate_leg #(
    .MIN_ON  (MIN_ON),
    .LOCKOUT (LOCKOUT)
  ) u_leg_hi (
    .CLK          (CLK),
    .RST          (RST),
    .i_run_ok     (w_run_ok),
    .i_req        (r_u_hi),
    .i_req_opp    (r_u_lo),
    .i_g_opp      (w_g_lo),
    .i_offcnt_opp (w_off_lo),
    .o_g          (w_g_hi),
    .o_offcnt     (w_off_hi)
  );

  gate_leg #(
    .MIN_ON  (MIN_ON),
    .LOCKOUT (LOCKOUT)
  ) u_leg_lo (
    .CLK          (CLK),
    .RST          (RST),
    .i_run_ok     (w_run_ok),
    .i_req        (r_u_lo),
    .i_req_opp    (r_u_hi),
    .i_g_opp      (w_g_hi),
    .i_offcnt_opp (w_off_hi),
    .o_g          (w_g_lo),
    .o_offcnt     (w_off_lo)
  );

  assign G_Hi    = w_g_hi;
  assign G_Lo    = w_g_lo;
  assign Running = (r_state == ST_RUN);
  assign Fault   = (r_state == ST_TRIP);
  assign Ovl     = r_ovl;

endmodule

// File: tb/tb_pwm_gate_guard.sv
// tb/tb_pwm_gate_guard.sv - self-checking bench for pwm_gate_guard against a timestamp-based model
module tb_pwm_gate_guard;

  localparam logic [15:0] MIN_ON   = 16'h0010;
  localparam logic [15:0] LOCKOUT  = 16'h0008;
  localparam int          FLT_FILT = 4;
  localparam int          P_MIN_ON = 16;
  localparam int          P_LOCK   = 8;
  localparam int          NMAX     = 8000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Enable = 1'b0, Fault_n = 1'b1, FltClr = 1'b0;
  logic Down_in = 1'b0, U_Hi_in = 1'b0, U_Lo_in = 1'b0;
  logic G_Hi, G_Lo, Running, Fault, Ovl;

  always #5 CLK = ~CLK;

  pwm_gate_guard #(
    .MIN_ON   (MIN_ON),
    .LOCKOUT  (LOCKOUT),
    .FLT_FILT (FLT_FILT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Enable  (Enable),
    .Fault_n (Fault_n),
    .FltClr  (FltClr),
    .Down_in (Down_in),
    .U_Hi_in (U_Hi_in),
    .U_Lo_in (U_Lo_in),
    .G_Hi    (G_Hi),
    .G_Lo    (G_Lo),
    .Running (Running),
    .Fault   (Fault),
    .Ovl     (Ovl)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  int base = 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Input values sampled at each rising edge index
  bit h_uhi [NMAX];
  bit h_ulo [NMAX];
  bit h_down[NMAX];
  bit h_fn  [NMAX];
  bit h_en  [NMAX];
  bit h_clr [NMAX];

  function automatic bit s_uhi(input int k);  return (k >= base) ? h_uhi[k]  : 1'b0; endfunction
  function automatic bit s_ulo(input int k);  return (k >= base) ? h_ulo[k]  : 1'b0; endfunction
  function automatic bit s_down(input int k); return (k >= base) ? h_down[k] : 1'b0; endfunction
  function automatic bit s_fn(input int k);   return (k >= base) ? h_fn[k]   : 1'b1; endfunction

  // Fault counts as active once it has been seen low, through two sync stages,
  // for FLT_FILT consecutive samples
  function automatic bit flt_after(input int k);
    for (int j = 1; j <= FLT_FILT; j++) if (s_fn(k - 1 - j)) return 1'b0;
    return 1'b1;
  endfunction

  typedef enum int {M_IDLE, M_ARM, M_RUN, M_TRIP} mstate_t;
  mstate_t m_st;
  bit m_ghi, m_glo, m_ovl;
  int t_hi_rise, t_hi_fall, t_lo_rise, t_lo_fall;

  task automatic model_reset();
    m_st = M_IDLE; m_ghi = 0; m_glo = 0; m_ovl = 0;
    t_hi_rise = 0; t_lo_rise = 0;
    t_hi_fall = -100000; t_lo_fall = -100000;
  endtask

  // Advance the model across rising edge n using what was registered at edge n-1
  task automatic model_step();
    bit flt, valley, rqh, rql, run_ok, nhi, nlo;
    flt    = flt_after(n - 1);
    valley = s_down(n - 2) && !s_down(n - 1);
    rqh    = s_uhi(n - 1);
    rql    = s_ulo(n - 1);
    run_ok = (m_st == M_RUN) && h_en[n] && !flt;
    if (m_ghi) nhi = run_ok && !(!rqh && (n - t_hi_rise >= P_MIN_ON));
    else       nhi = run_ok && rqh && !rql && !m_glo && (n - t_lo_fall > P_LOCK);
    if (m_glo) nlo = run_ok && !(!rql && (n - t_lo_rise >= P_MIN_ON));
    else       nlo = run_ok && rql && !rqh && !m_ghi && (n - t_hi_fall > P_LOCK);
    if (nhi && !m_ghi) t_hi_rise = n;
    if (!nhi && m_ghi) t_hi_fall = n;
    if (nlo && !m_glo) t_lo_rise = n;
    if (!nlo && m_glo) t_lo_fall = n;
    m_ghi = nhi;
    m_glo = nlo;
    if (flt) m_st = M_TRIP;
    else case (m_st)
      M_IDLE: if (h_en[n]) m_st = M_ARM;
      M_ARM:  if (!h_en[n]) m_st = M_IDLE; else if (valley) m_st = M_RUN;
      M_RUN:  if (!h_en[n]) m_st = M_IDLE;
      M_TRIP: if (h_clr[n] && !h_en[n]) m_st = M_IDLE;
      default: m_st = M_IDLE;
    endcase
    m_ovl = rqh && rql;
  endtask

  // One clock: record inputs, let the edge happen, step the model, compare at the falling edge
  task automatic tick();
    n++;
    h_uhi[n] = U_Hi_in; h_ulo[n] = U_Lo_in; h_down[n] = Down_in;
    h_fn[n] = Fault_n; h_en[n] = Enable; h_clr[n] = FltClr;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    chk("outputs", {11'd0, G_Hi, G_Lo, Running, Fault, Ovl},
        {11'd0, m_ghi, m_glo, m_st == M_RUN, m_st == M_TRIP, m_ovl});
    chk("overlap", {15'd0, G_Hi & G_Lo}, 16'd0);
  endtask

  initial begin
    int t_fall, t_rise, cnt, novl, ng, nf, lat, car, per, fault_left, mode, len;

    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset", {11'd0, G_Hi, G_Lo, Running, Fault, Ovl}, 16'd0);
    RST = 1'b0;
    base = n + 1;

    // Start only on a carrier valley
    Enable = 1; U_Hi_in = 1; Down_in = 1;
    repeat (3) tick();
    Down_in = 0;
    tick(); chk("t1_arm_run", {15'd0, Running}, 16'd0); chk("t1_arm_ghi", {15'd0, G_Hi}, 16'd0);
    tick(); chk("t1_run", {15'd0, Running}, 16'd1); chk("t1_ghi_pre", {15'd0, G_Hi}, 16'd0);
    tick(); chk("t1_ghi", {15'd0, G_Hi}, 16'd1);

    // Lockout gap between G_Lo falling and G_Hi rising
    U_Hi_in = 0; U_Lo_in = 1;
    repeat (40) tick();
    U_Lo_in = 0;
    t_fall = -1; t_rise = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) U_Hi_in = 1;
      tick();
      if (t_fall < 0 && !G_Lo) t_fall = i;
      if (t_rise < 0 && G_Hi) t_rise = i;
    end
    chk("t2_gap", 16'(t_rise - t_fall), 16'd9);

    // Minimum on-time: short pulse stretched, long pulse passed through
    U_Hi_in = 0;
    repeat (30) tick();
    cnt = 0;
    for (int i = 0; i < 60; i++) begin U_Hi_in = (i < 3); tick(); cnt += int'(G_Hi); end
    chk("t3_w3", 16'(cnt), 16'd16);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin U_Hi_in = (i < 20); tick(); cnt += int'(G_Hi); end
    chk("t3_w20", 16'(cnt), 16'd20);

    // Both requests high: flag each cycle, no gate turns on
    novl = 0; ng = 0;
    for (int i = 0; i < 12; i++) begin
      U_Hi_in = (i < 5); U_Lo_in = (i < 5);
      tick();
      novl += int'(Ovl); ng += int'(G_Hi | G_Lo);
    end
    chk("t5_ovl", 16'(novl), 16'd5);
    chk("t5_gates", 16'(ng), 16'd0);

    // Fault filter, trip latency, clear handshake
    U_Hi_in = 1;
    repeat (5) tick();
    nf = 0;
    for (int i = 0; i < 15; i++) begin Fault_n = !(i < 3); tick(); nf += int'(Fault); end
    chk("t4_short", 16'(nf), 16'd0);
    lat = -1;
    for (int i = 0; i < 15; i++) begin
      Fault_n = !(i < 4);
      tick();
      if (lat < 0 && Fault) lat = i + 1;
    end
    chk("t4_trip_in_7", {15'd0, lat >= 1 && lat <= 7}, 16'd1);
    chk("t4_gates", {14'd0, G_Hi, G_Lo}, 16'd0);
    FltClr = 1;
    repeat (5) tick();
    chk("t4_hold", {15'd0, Fault}, 16'd1);
    Enable = 0;
    tick();
    chk("t4_clr", {14'd0, Fault, Running}, 16'd0);
    FltClr = 0;

    // Asynchronous reset mid-run
    Enable = 1; U_Hi_in = 1; Down_in = 1;
    repeat (2) tick();
    Down_in = 0;
    repeat (4) tick();
    chk("t6_pre", {15'd0, G_Hi}, 16'd1);
    #2 RST = 1'b1;
    #1 chk("t6_rst", {14'd0, G_Hi, Running}, 16'd0);
    #1 RST = 1'b0;
    model_reset();
    base = n + 1;
    repeat (6) tick();
    chk("t6_no_valley", {15'd0, Running}, 16'd0);
    Down_in = 1; tick(); Down_in = 0;
    repeat (3) tick();
    chk("t6_rerun", {15'd0, Running}, 16'd1);

    // Randomised traffic
    car = 0; per = $urandom_range(8, 24); fault_left = 0;
    for (int seg = 0; seg < 120; seg++) begin
      mode = $urandom_range(0, 10);
      len  = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        car++;
        if (car >= per) begin Down_in = !Down_in; car = 0; per = $urandom_range(8, 24); end
        U_Hi_in = (mode <= 3) || (mode == 9);
        U_Lo_in = (mode >= 4 && mode <= 7) || (mode == 9);
        Enable  = (mode != 10);
        if (fault_left > 0) begin
          Fault_n = 0; fault_left--;
        end else begin
          Fault_n = 1;
          if ($urandom_range(0, 199) == 0) fault_left = $urandom_range(1, 6);
        end
        FltClr = (m_st == M_TRIP) && ($urandom_range(0, 3) == 0);
        if (m_st == M_TRIP && $urandom_range(0, 2) == 0) Enable = 0;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
